// File: rtl/aibcr3_dcc_cal_ctrl.sv
// DCC delay-line calibration controller: 11-bit successive-approximation search
// on a phase-detector result. Define AIBCR3_DCC_CAL_TRACK_EN to enable post-lock tracking.
module aibcr3_dcc_cal_ctrl (
  input  logic        clk,
  input  logic        rstb,
  input  logic        cal_start,
  input  logic [3:0]  settle_cfg,
  input  logic        pd_out,
  output logic        launch,
  output logic        measure,
  output logic [10:0] gray,
  output logic [10:0] code_bin,
  output logic        dll_lock_reg,
  output logic        cal_busy,
  output logic        cal_done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_FIRE   = 3'd2,
    ST_EVAL   = 3'd3,
    ST_LOCK   = 3'd4
  } state_e;

  localparam logic [10:0] CODE_MSB = 11'h400;
  localparam logic [10:0] CODE_MAX = 11'h7FF;
  localparam logic [3:0]  BIT_MSB  = 4'd10;

  // Reset asserts asynchronously but releases two clk edges after rstb rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) rst_sync_q <= 2'b00;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_e      state_q, state_d;
  logic [3:0]  bit_q, bit_d;
  logic [3:0]  wait_q, wait_d;
  logic [10:0] code_q, code_d;
  logic [10:0] gray_q, gray_d;
  logic [10:0] bit_mask;
  logic        launch_q, launch_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        lock_q, lock_d;
  logic        start_cal;
`ifdef AIBCR3_DCC_CAL_TRACK_EN
  logic [5:0]  trk_cnt_q, trk_cnt_d;
`endif

  assign start_cal = cal_start && ((state_q == ST_IDLE) || (state_q == ST_LOCK));
  assign bit_mask  = 11'd1 << bit_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    wait_d  = wait_q;
    code_d  = code_q;
`ifdef AIBCR3_DCC_CAL_TRACK_EN
    trk_cnt_d = 6'd0;
`endif

    if (start_cal) begin
      state_d = ST_SETTLE;
      code_d  = CODE_MSB;
      bit_d   = BIT_MSB;
      wait_d  = settle_cfg;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_SETTLE: begin
          if (wait_q == 4'd0) state_d = ST_FIRE;
          else                wait_d  = wait_q - 4'd1;
        end
        ST_FIRE: begin
          state_d = ST_EVAL;
          wait_d  = settle_cfg;
        end
        ST_EVAL: begin
          if (wait_q != 4'd0) begin
            wait_d = wait_q - 4'd1;
          end else begin
            // Late delay-line edge means the trial code overshoots: drop the bit.
            if (pd_out) code_d = code_d & ~bit_mask;
            if (bit_q != 4'd0) begin
              code_d  = code_d | (bit_mask >> 1);
              bit_d   = bit_q - 4'd1;
              wait_d  = settle_cfg;
              state_d = ST_SETTLE;
            end else begin
              state_d = ST_LOCK;
            end
          end
        end
        ST_LOCK: begin
`ifdef AIBCR3_DCC_CAL_TRACK_EN
          trk_cnt_d = trk_cnt_q + 6'd1;
          if (trk_cnt_q == 6'd63) begin
            if (pd_out) begin
              if (code_q != 11'd0) code_d = code_q - 11'd1;
            end else begin
              if (code_q != CODE_MAX) code_d = code_q + 11'd1;
            end
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_comb begin
    launch_d = (state_d == ST_FIRE);
    busy_d   = (state_d == ST_SETTLE) || (state_d == ST_FIRE) || (state_d == ST_EVAL);
    lock_d   = (state_d == ST_LOCK);
    done_d   = lock_d && (state_q != ST_LOCK);
    gray_d   = code_d ^ (code_d >> 1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bit_q    <= BIT_MSB;
      wait_q   <= 4'd0;
      code_q   <= 11'd0;
      gray_q   <= 11'd0;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      wait_q   <= wait_d;
      code_q   <= code_d;
      gray_q   <= gray_d;
      launch_q <= launch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      lock_q   <= lock_d;
    end
  end

`ifdef AIBCR3_DCC_CAL_TRACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trk_cnt_q <= 6'd0;
    else        trk_cnt_q <= trk_cnt_d;
  end
`endif

  assign launch       = launch_q;
  assign measure      = launch_q;
  assign gray         = gray_q;
  assign code_bin     = code_q;
  assign dll_lock_reg = lock_q;
  assign cal_busy     = busy_q;
  assign cal_done     = done_q;

endmodule

// File: tb/tb_aibcr3_dcc_cal_ctrl.sv
// Self-checking bench for aibcr3_dcc_cal_ctrl: randomized calibrations against a
// reference model of the search result and timing. Honors AIBCR3_DCC_CAL_TRACK_EN.
module tb_aibcr3_dcc_cal_ctrl;

  logic        clk = 1'b0;
  logic        rstb;
  logic        cal_start;
  logic [3:0]  settle_cfg;
  logic        pd_out;
  logic        launch, measure, dll_lock_reg, cal_busy, cal_done;
  logic [10:0] gray, code_bin;

  always #5 clk = ~clk;

  aibcr3_dcc_cal_ctrl dut (
    .clk          (clk),
    .rstb         (rstb),
    .cal_start    (cal_start),
    .settle_cfg   (settle_cfg),
    .pd_out       (pd_out),
    .launch       (launch),
    .measure      (measure),
    .gray         (gray),
    .code_bin     (code_bin),
    .dll_lock_reg (dll_lock_reg),
    .cal_busy     (cal_busy),
    .cal_done     (cal_done)
  );

  // Phase-detector plant: threshold on the current code, or a constant level.
  logic        pd_mode;
  logic        pd_const;
  logic [11:0] thr;

  always_comb pd_out = pd_mode ? pd_const : ({1'b0, code_bin} > thr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit pd_model(input int c);
    return pd_mode ? pd_const : (c > int'(thr));
  endfunction

  // Result is the largest code the detector calls early, else zero.
  function automatic int sar_expect();
    for (int c = 2047; c >= 0; c--)
      if (!pd_model(c)) return c;
    return 0;
  endfunction

  int busy_cyc, n_launch, spacing_bad, first_launch, n_done, lm_bad;
  bit locked;

  task automatic run_cal(input int s, input bit hold);
    int prev;
    int idx;
    busy_cyc = 0; n_launch = 0; spacing_bad = 0; first_launch = -1;
    n_done = 0; lm_bad = 0; locked = 0; prev = -1; idx = 0;
    settle_cfg = 4'(s);
    cal_start  = 1'b1;
    @(negedge clk);
    if (!hold) cal_start = 1'b0;
    check("start_busy_nolock", {30'd0, cal_busy, dll_lock_reg}, 32'd2);
    for (int k = 0; k < 2000 && !locked; k++) begin
      if (cal_busy) busy_cyc++;
      if (launch !== measure) lm_bad++;
      if (launch) begin
        if (prev < 0) first_launch = idx;
        else if (idx - prev != 2 * s + 3) spacing_bad++;
        prev = idx;
        n_launch++;
      end
      if (cal_done) n_done++;
      if (dll_lock_reg && !cal_busy) begin
        cal_start = 1'b0;
        locked = 1;
      end else begin
        idx++;
        @(negedge clk);
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (cal_done) n_done++;
    end
  endtask

  task automatic verify_run(input string tag, input int s, input int exp);
    int exp_gray;
    exp_gray = exp ^ (exp >> 1);
    check({tag, "_locked"},      32'(locked), 32'd1);
    check({tag, "_busy_cycles"}, busy_cyc, 11 * (2 * s + 3));
    check({tag, "_launches"},    n_launch, 11);
    check({tag, "_first_fire"},  first_launch, s + 1);
    check({tag, "_spacing"},     spacing_bad, 0);
    check({tag, "_launch_eq_measure"}, lm_bad, 0);
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_code"},        32'(code_bin), exp);
    check({tag, "_gray"},        32'(gray), exp_gray);
    check({tag, "_lock"},        32'(dll_lock_reg), 32'd1);
  endtask

  function automatic logic [31:0] all_outs();
    return {6'd0, launch, measure, gray, code_bin, dll_lock_reg, cal_busy, cal_done};
  endfunction

  int s_r;
  int exp_r;
  int n_seen;

  initial begin
    rstb = 1'b0; cal_start = 1'b0; settle_cfg = 4'd0;
    pd_mode = 1'b0; pd_const = 1'b0; thr = 12'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 32'd0);
    rstb = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_after_release", {29'd0, cal_busy, dll_lock_reg, cal_done}, 32'd0);

    thr = 12'd1000;
    run_cal(0, 0);
    verify_run("s0_thr1000", 0, sar_expect());
    check("s0_gray540", 32'(gray), 32'd540);

    pd_mode = 1'b1; pd_const = 1'b1;
    run_cal(3, 0);
    verify_run("s3_pd_high", 3, sar_expect());
    pd_mode = 1'b0;

    for (int r = 0; r < 4; r++) begin
      s_r = $urandom_range(0, 15);
      thr = 12'($urandom_range(0, 2047));
      run_cal(s_r, 0);
      verify_run("rand", s_r, sar_expect());
    end

    thr = 12'($urandom_range(0, 2047));
    run_cal(2, 1);
    verify_run("held_start", 2, sar_expect());
    thr = 12'($urandom_range(0, 2047));
    run_cal(1, 0);
    verify_run("restart_from_lock", 1, sar_expect());

    thr = 12'($urandom_range(0, 2047));
    settle_cfg = 4'd1;
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    n_seen = 0;
    for (int k = 0; k < 500 && n_seen < 5; k++) begin
      if (launch) n_seen++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("mid_cal_busy", 32'(cal_busy), 32'd1);
    #2 rstb = 1'b0;
    #1 check("async_reset_outputs", all_outs(), 32'd0);
    n_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (cal_done || cal_busy) n_done++;
    end
    check("abort_no_done", n_done, 0);

    cal_start = 1'b1;
    rstb = 1'b1;
    @(negedge clk);
    check("sync_edge1_idle", 32'(cal_busy), 32'd0);
    repeat (2) @(negedge clk);
    check("sync_edge3_busy", 32'(cal_busy), 32'd1);
    cal_start = 1'b0;
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (4) @(negedge clk);
    thr = 12'($urandom_range(0, 2047));
    run_cal(2, 0);
    verify_run("fresh_after_reset", 2, sar_expect());

`ifdef AIBCR3_DCC_CAL_TRACK_EN
    pd_mode = 1'b1; pd_const = 1'b0;
    run_cal(0, 0);
    verify_run("trk_lock_max", 0, sar_expect());
    repeat (130) @(negedge clk);
    check("trk_saturate_max", 32'(code_bin), 32'd2047);
    pd_const = 1'b1;
    for (int k = 0; k < 70 && code_bin == 11'd2047; k++) @(negedge clk);
    check("trk_step_down", 32'(code_bin), 32'd2046);
    check("trk_lock_held", 32'(dll_lock_reg), 32'd1);
`else
    thr = 12'($urandom_range(0, 2047));
    exp_r = sar_expect();
    run_cal(0, 0);
    verify_run("frz_lock", 0, exp_r);
    pd_mode = 1'b1; pd_const = 1'b0;
    repeat (200) @(negedge clk);
    check("frz_pd_low", 32'(code_bin), exp_r);
    pd_const = 1'b1;
    repeat (100) @(negedge clk);
    check("frz_pd_high", 32'(code_bin), exp_r);
    check("frz_lock_held", 32'(dll_lock_reg), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/aibcr3_dcc_cal_ctrl.md
AIBCR3_DCC_CAL_CTRL -- requirements
Module: aibcr3_dcc_cal_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  calibration clock, all state on rising edge.
REQ-002 SHALL have port: rstb  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: cal_start  input  1  level-sampled request to begin a calibration from IDLE or LOCK.
REQ-004 SHALL have port: settle_cfg  input  4  settle wait S; each wait phase lasts S+1 cycles.
REQ-005 SHALL have port: pd_out  input  1  phase-detector result; 1 means the delay-line edge is later than the min-delay edge.
REQ-006 SHALL have port: launch  output  1  one-cycle pulse into the delay-line input mux.
REQ-007 SHALL have port: measure  output  1  one-cycle pulse into the min-delay input mux; always equal to launch.
REQ-008 SHALL have port: gray  output  11  registered delay-line code, gray = code_bin ^ (code_bin >> 1).
REQ-009 SHALL have port: code_bin  output  11  registered binary code.
REQ-010 SHALL have port: dll_lock_reg  output  1  1 selects clk_dcd at the delay-line muxes (locked).
REQ-011 SHALL have port: cal_busy  output  1  high in every state except IDLE and LOCK.
REQ-012 SHALL have port: cal_done  output  1  one-cycle pulse on entry to LOCK.

Function
REQ-013 SHALL implement the states IDLE, SETTLE, FIRE, EVAL and LOCK, plus a bit index b (10 down to 0).
REQ-014 IDLE with cal_start=1 SHALL, on that edge, clear code_bin, set code_bin[10]=1, set b=10 and enter SETTLE.
REQ-015 SETTLE SHALL hold for S+1 cycles and then enter FIRE.
REQ-016 FIRE SHALL last exactly 1 cycle with launch=measure=1 and then enter EVAL; launch and measure SHALL be 0 in every other state.
REQ-017 EVAL SHALL hold for S+1 cycles and sample pd_out on its last cycle.
REQ-018 On that EVAL sample, pd_out=1 SHALL clear code_bin[b]; pd_out=0 SHALL keep code_bin[b].
REQ-019 After the EVAL sample, if b>0 the block SHALL set code_bin[b-1]=1, decrement b and re-enter SETTLE; if b=0 it SHALL enter LOCK.
REQ-020 Each bit SHALL take 2S+3 cycles, and a full calibration SHALL take 11*(2S+3) cycles from the cal_busy rise to the LOCK entry.
REQ-021 On LOCK entry, dll_lock_reg SHALL go to 1 and cal_done SHALL be 1 for exactly one cycle.
REQ-022 gray SHALL update in the same cycle as code_bin, with no skew between the two.
REQ-023 cal_start while cal_busy=1 SHALL be ignored.
REQ-024 cal_start in LOCK SHALL clear dll_lock_reg on the next edge and restart the calibration exactly as from IDLE.
REQ-025 settle_cfg SHALL be sampled only when a wait phase begins; a change in mid-phase SHALL not alter that phase.
REQ-026 Result: code_bin SHALL equal the largest code whose pd_out sample was 0, or 0 if every sample was 1.

Reset
REQ-027 rstb=0 SHALL asynchronously force IDLE, b=10, code_bin=0, gray=0, launch=0, measure=0, dll_lock_reg=0, cal_busy=0, cal_done=0.
REQ-028 rstb asserted mid-calibration SHALL abort the calibration with no cal_done pulse.
REQ-029 rstb deassertion SHALL be synchronised to clk inside the block with a 2-flop synchroniser, so the FSM leaves reset on the 2nd edge after release.

Configuration
REQ-030 With macro AIBCR3_DCC_CAL_TRACK_EN defined, LOCK SHALL run a free-running 6-bit counter.
REQ-031 With the macro defined, on each counter wrap (every 64 cycles) the block SHALL sample pd_out and step code_bin by -1 if pd_out=1 or +1 if pd_out=0.
REQ-032 Tracking steps SHALL saturate at 0 and 2047, and dll_lock_reg SHALL stay 1 while tracking.
REQ-033 Without the macro, code_bin SHALL be frozen in LOCK and no counter logic SHALL exist.

Verification
REQ-034 S=0, pd_out model = (code_bin>1000), cal_start pulse -> cal_busy high for 33 cycles, then code_bin=1000, gray=540, dll_lock_reg=1, a single cal_done pulse.
REQ-035 S=3, pd_out held 1 -> 11 launch pulses spaced 9 cycles apart, code_bin=0, gray=0, lock after 99 cycles.
REQ-036 Reset asserted during bit 5 -> all outputs 0 immediately; cal_start after release -> full 11-bit calibration with a fresh result.
REQ-037 cal_start held continuously through the calibration -> no restart before LOCK; a second cal_start in LOCK -> dll_lock_reg drops and the search reruns.
REQ-038 AIBCR3_DCC_CAL_TRACK_EN defined, locked at 2047, pd_out=0 -> code_bin stays 2047; then pd_out=1 -> code_bin=2046 at the next 64-cycle wrap.
